// File: rtl/capi_tag_response_tracker_pkg.sv
// Shared types and constants for the PSL tag/response tracker.
package capi_tag_response_tracker_pkg;

    localparam int TAG_COUNT     = 256;
    localparam int TAG_BITS      = $clog2(TAG_COUNT);
    localparam int CU_ID_RANGE   = 8;
    localparam int CREDITS_TOTAL = 64;
    localparam int STAT_BITS     = 64;

    localparam logic [7:0] RSP_DONE    = 8'h00;
    localparam logic [7:0] RSP_AERROR  = 8'h01;
    localparam logic [7:0] RSP_DERROR  = 8'h03;
    localparam logic [7:0] RSP_NLOCK   = 8'h04;
    localparam logic [7:0] RSP_NRES    = 8'h05;
    localparam logic [7:0] RSP_FLUSHED = 8'h06;
    localparam logic [7:0] RSP_FAULT   = 8'h07;
    localparam logic [7:0] RSP_FAILED  = 8'h08;
    localparam logic [7:0] RSP_PAGED   = 8'h0A;

    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [CU_ID_RANGE-1:0] cu_id_t;
    typedef logic [STAT_BITS-1:0]   stat_t;

    localparam tag_t  INVALID_TAG = '0;
    localparam tag_t  LAST_TAG    = tag_t'(TAG_COUNT - 1);
    localparam stat_t STAT_ONE    = stat_t'(1);

    typedef struct packed {
        logic   valid;
        cu_id_t cu_id;
    } tag_entry_t;

    typedef struct packed {
        stat_t done;
        stat_t aerror;
        stat_t derror;
        stat_t nlock;
        stat_t nres;
        stat_t flushed;
        stat_t fault;
        stat_t failed;
        stat_t paged;
    } stats_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } trk_state_e;

endpackage

// File: rtl/capi_tag_response_tracker_fifo.sv
// Free-tag FIFO: wrapping pointers plus occupancy count, with a
// separate load port used to seed it after reset.
module tag_free_list_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_data;

    assign wr_en   = load_en | push;
    assign wr_data = load_en ? load_data : push_data;
    assign rd_en   = pop & ~empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/capi_tag_response_tracker.sv
// Issues PSL tags against credits, routes responses back to the
// issuing CU and keeps per-response-code statistics.
module capi_tag_response_tracker
    import capi_tag_response_tracker_pkg::*;
(
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   stats_clear_in,
    output logic                   ready_out,
    input  logic                   cmd_req_in,
    input  logic [CU_ID_RANGE-1:0] cmd_cu_id_in,
    output logic                   cmd_grant_out,
    output logic [TAG_BITS-1:0]    cmd_tag_out,
    input  logic                   rsp_valid_in,
    input  logic [TAG_BITS-1:0]    rsp_tag_in,
    input  logic [7:0]             rsp_code_in,
    input  logic [8:0]             rsp_credits_in,
    output logic                   rsp_valid_out,
    output logic [CU_ID_RANGE-1:0] rsp_cu_id_out,
    output logic [TAG_BITS-1:0]    rsp_tag_out,
    output logic [7:0]             rsp_code_out,
    output logic [6:0]             credits_out,
    output logic [8:0]             outstanding_out,
    output logic                   error_out,
    output logic [TAG_BITS-1:0]    error_tag_out,
    output logic [STAT_BITS-1:0]   done_count_out,
    output logic [STAT_BITS-1:0]   aerror_count_out,
    output logic [STAT_BITS-1:0]   derror_count_out,
    output logic [STAT_BITS-1:0]   nlock_count_out,
    output logic [STAT_BITS-1:0]   nres_count_out,
    output logic [STAT_BITS-1:0]   flushed_count_out,
    output logic [STAT_BITS-1:0]   fault_count_out,
    output logic [STAT_BITS-1:0]   failed_count_out,
    output logic [STAT_BITS-1:0]   paged_count_out
);

    localparam logic signed [10:0] CRED_MAX = 11'(CREDITS_TOTAL);

    trk_state_e state;
    tag_t       init_tag;
    tag_t       fl_head;
    logic       fl_empty;
    tag_entry_t tag_table [TAG_COUNT];
    tag_entry_t rsp_entry;
    stats_t     stats;
    logic       rsp_hit;
    logic       rsp_err;
    logic       cred_over;
    logic       cred_under;
    logic signed [10:0] cred_ret;
    logic signed [10:0] cred_sum;

    tag_free_list_fifo #(
        .DEPTH (TAG_COUNT),
        .WIDTH (TAG_BITS)
    ) u_free_list (
        .clk       (clock),
        .rst_n     (rstn),
        .load_en   (state == ST_INIT),
        .load_data (init_tag),
        .push      (rsp_hit),
        .push_data (rsp_tag_in),
        .pop       (cmd_grant_out),
        .head      (fl_head),
        .empty     (fl_empty)
    );

    assign cmd_tag_out   = fl_head;
    assign cmd_grant_out = cmd_req_in & ready_out & ~fl_empty
                         & (credits_out != '0);

    assign rsp_entry = tag_table[rsp_tag_in];
    assign rsp_hit   = rsp_valid_in & (state == ST_RUN)
                     & (rsp_tag_in != INVALID_TAG) & rsp_entry.valid;
    assign rsp_err   = rsp_valid_in & ~rsp_hit;

    // Returned credits and the grant decrement land in one update.
    assign cred_ret   = rsp_valid_in
                      ? $signed({{2{rsp_credits_in[8]}}, rsp_credits_in})
                      : 11'sd0;
    assign cred_sum   = $signed({4'b0000, credits_out}) + cred_ret
                      - (cmd_grant_out ? 11'sd1 : 11'sd0);
    assign cred_over  = cred_sum > CRED_MAX;
    assign cred_under = cred_sum < 11'sd0;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_INIT;
            init_tag  <= tag_t'(1);
            ready_out <= 1'b0;
        end else if (state == ST_INIT) begin
            init_tag <= init_tag + tag_t'(1);
            if (init_tag == LAST_TAG) begin
                state     <= ST_RUN;
                ready_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAG_COUNT; i++) tag_table[i] <= '0;
        end else begin
            if (cmd_grant_out) tag_table[fl_head] <= '{1'b1, cmd_cu_id_in};
            if (rsp_hit) tag_table[rsp_tag_in].valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            credits_out     <= 7'(CREDITS_TOTAL);
            outstanding_out <= '0;
            error_out       <= 1'b0;
            error_tag_out   <= '0;
            rsp_valid_out   <= 1'b0;
            rsp_cu_id_out   <= '0;
            rsp_tag_out     <= '0;
            rsp_code_out    <= '0;
        end else begin
            if (cred_over)       credits_out <= 7'(CREDITS_TOTAL);
            else if (cred_under) credits_out <= '0;
            else                 credits_out <= cred_sum[6:0];
            outstanding_out <= outstanding_out
                             + {8'b0, cmd_grant_out}
                             - {8'b0, rsp_hit};
            if (!error_out && (rsp_err || cred_over)) begin
                error_out     <= 1'b1;
                error_tag_out <= rsp_tag_in;
            end
            rsp_valid_out <= rsp_hit;
            if (rsp_hit) begin
                rsp_cu_id_out <= rsp_entry.cu_id;
                rsp_tag_out   <= rsp_tag_in;
                rsp_code_out  <= rsp_code_in;
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            stats <= '0;
        end else if (stats_clear_in) begin
            stats <= '0;
        end else if (rsp_hit) begin
            unique case (rsp_code_in)
                RSP_DONE:    stats.done    <= stats.done    + STAT_ONE;
                RSP_AERROR:  stats.aerror  <= stats.aerror  + STAT_ONE;
                RSP_DERROR:  stats.derror  <= stats.derror  + STAT_ONE;
                RSP_NLOCK:   stats.nlock   <= stats.nlock   + STAT_ONE;
                RSP_NRES:    stats.nres    <= stats.nres    + STAT_ONE;
                RSP_FLUSHED: stats.flushed <= stats.flushed + STAT_ONE;
                RSP_FAULT:   stats.fault   <= stats.fault   + STAT_ONE;
                RSP_FAILED:  stats.failed  <= stats.failed  + STAT_ONE;
                RSP_PAGED:   stats.paged   <= stats.paged   + STAT_ONE;
                default:     stats         <= stats;
            endcase
        end
    end

    assign done_count_out    = stats.done;
    assign aerror_count_out  = stats.aerror;
    assign derror_count_out  = stats.derror;
    assign nlock_count_out   = stats.nlock;
    assign nres_count_out    = stats.nres;
    assign flushed_count_out = stats.flushed;
    assign fault_count_out   = stats.fault;
    assign failed_count_out  = stats.failed;
    assign paged_count_out   = stats.paged;

endmodule

// File: tb/tb_capi_tag_response_tracker.sv
// Scoreboard bench for the tag/response tracker: a reference model
// predicts grants, credits and statistics; routed responses are queued.
module tb_capi_tag_response_tracker;
    import capi_tag_response_tracker_pkg::*;

    logic        clock = 1'b0;
    logic        rstn  = 1'b0;
    logic        stats_clear_in;
    logic        ready_out;
    logic        cmd_req_in;
    logic [7:0]  cmd_cu_id_in;
    logic        cmd_grant_out;
    logic [7:0]  cmd_tag_out;
    logic        rsp_valid_in;
    logic [7:0]  rsp_tag_in;
    logic [7:0]  rsp_code_in;
    logic [8:0]  rsp_credits_in;
    logic        rsp_valid_out;
    logic [7:0]  rsp_cu_id_out;
    logic [7:0]  rsp_tag_out;
    logic [7:0]  rsp_code_out;
    logic [6:0]  credits_out;
    logic [8:0]  outstanding_out;
    logic        error_out;
    logic [7:0]  error_tag_out;
    logic [63:0] done_count_out, aerror_count_out, derror_count_out;
    logic [63:0] nlock_count_out, nres_count_out, flushed_count_out;
    logic [63:0] fault_count_out, failed_count_out, paged_count_out;

    always #5 clock = ~clock;

    capi_tag_response_tracker dut (
        .clock             (clock),
        .rstn              (rstn),
        .stats_clear_in    (stats_clear_in),
        .ready_out         (ready_out),
        .cmd_req_in        (cmd_req_in),
        .cmd_cu_id_in      (cmd_cu_id_in),
        .cmd_grant_out     (cmd_grant_out),
        .cmd_tag_out       (cmd_tag_out),
        .rsp_valid_in      (rsp_valid_in),
        .rsp_tag_in        (rsp_tag_in),
        .rsp_code_in       (rsp_code_in),
        .rsp_credits_in    (rsp_credits_in),
        .rsp_valid_out     (rsp_valid_out),
        .rsp_cu_id_out     (rsp_cu_id_out),
        .rsp_tag_out       (rsp_tag_out),
        .rsp_code_out      (rsp_code_out),
        .credits_out       (credits_out),
        .outstanding_out   (outstanding_out),
        .error_out         (error_out),
        .error_tag_out     (error_tag_out),
        .done_count_out    (done_count_out),
        .aerror_count_out  (aerror_count_out),
        .derror_count_out  (derror_count_out),
        .nlock_count_out   (nlock_count_out),
        .nres_count_out    (nres_count_out),
        .flushed_count_out (flushed_count_out),
        .fault_count_out   (fault_count_out),
        .failed_count_out  (failed_count_out),
        .paged_count_out   (paged_count_out)
    );

    typedef struct {
        logic [7:0] cu;
        logic [7:0] tag;
        logic [7:0] code;
    } rsp_exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_cred = 64;
    int          m_out = 0;
    bit          m_err = 0;
    logic [7:0]  m_err_tag = '0;
    bit          m_valid [256];
    logic [7:0]  m_cu [256];
    longint      m_stat [9];
    logic [7:0]  fl [$];
    logic [7:0]  infl [$];
    rsp_exp_t    sb [$];
    bit          last_grant;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int code_idx(input logic [7:0] c);
        case (c)
            8'h00: return 0;
            8'h01: return 1;
            8'h03: return 2;
            8'h04: return 3;
            8'h05: return 4;
            8'h06: return 5;
            8'h07: return 6;
            8'h08: return 7;
            8'h0A: return 8;
            default: return -1;
        endcase
    endfunction

    function automatic logic [63:0] dut_stat(input int i);
        case (i)
            0: return done_count_out;
            1: return aerror_count_out;
            2: return derror_count_out;
            3: return nlock_count_out;
            4: return nres_count_out;
            5: return flushed_count_out;
            6: return fault_count_out;
            7: return failed_count_out;
            default: return paged_count_out;
        endcase
    endfunction

    task automatic idle_inputs();
        cmd_req_in = 0; cmd_cu_id_in = '0; rsp_valid_in = 0;
        rsp_tag_in = '0; rsp_code_in = '0; rsp_credits_in = '0;
        stats_clear_in = 0;
    endtask

    // One clock of stimulus; entered and left on a falling edge.
    task automatic step(input bit req, input logic [7:0] cu, input bit rv,
                        input logic [7:0] rtag, input logic [7:0] code,
                        input int cred, input bit clr);
        bit g, hit;
        int c, idx;
        logic [7:0] t;
        rsp_exp_t e;
        cmd_req_in = req; cmd_cu_id_in = cu; rsp_valid_in = rv;
        rsp_tag_in = rtag; rsp_code_in = code;
        rsp_credits_in = 9'(cred); stats_clear_in = clr;
        #1;
        g = req && (fl.size() > 0) && (m_cred != 0);
        last_grant = cmd_grant_out;
        chk("grant", cmd_grant_out, g);
        if (g) chk("grant_tag", cmd_tag_out, fl[0]);
        hit = rv && (rtag != 0) && m_valid[rtag];
        c = m_cred + (rv ? cred : 0) - (g ? 1 : 0);
        if (rv && (!hit || c > 64) && !m_err) begin
            m_err = 1;
            m_err_tag = rtag;
        end
        m_cred = (c < 0) ? 0 : (c > 64) ? 64 : c;
        if (g) begin
            t = fl.pop_front();
            m_valid[t] = 1;
            m_cu[t] = cu;
            infl.push_back(t);
            m_out++;
        end
        if (hit) begin
            e.cu = m_cu[rtag]; e.tag = rtag; e.code = code;
            sb.push_back(e);
            m_valid[rtag] = 0;
            fl.push_back(rtag);
            m_out--;
            for (int i = 0; i < infl.size(); i++)
                if (infl[i] == rtag) begin
                    infl.delete(i);
                    break;
                end
            idx = code_idx(code);
            if (idx >= 0) m_stat[idx]++;
        end
        if (clr) for (int i = 0; i < 9; i++) m_stat[i] = 0;
        @(negedge clock);
        idle_inputs();
        chk("rsp_valid", rsp_valid_out, hit);
        chk("credits", credits_out, m_cred);
        chk("outstanding", outstanding_out, m_out);
        chk("error", error_out, m_err);
        if (m_err) chk("error_tag", error_tag_out, m_err_tag);
        for (int i = 0; i < 9; i++) chk($sformatf("stat%0d", i), dut_stat(i), m_stat[i]);
    endtask

    always @(negedge clock) begin
        rsp_exp_t e;
        if (rstn && rsp_valid_out) begin
            chk("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_cu", rsp_cu_id_out, e.cu);
                chk("rsp_tag", rsp_tag_out, e.tag);
                chk("rsp_code", rsp_code_out, e.code);
            end
        end
    end

    initial begin
        int cycles;
        int ngrant;
        idle_inputs();
        for (int i = 0; i < 9; i++) m_stat[i] = 0;
        repeat (3) @(negedge clock);
        chk("rst_ready", ready_out, 0);
        chk("rst_credits", credits_out, 64);
        chk("rst_outstanding", outstanding_out, 0);
        chk("rst_error", error_out, 0);
        chk("rst_rsp_valid", rsp_valid_out, 0);
        rstn = 1;

        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!ready_out && cycles < 400);
        chk("ready_cycles", cycles, 255);
        if (!ready_out) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
        for (int t = 1; t < 256; t++) fl.push_back(8'(t));

        // three grants to CU 5, then DONE for tag 2
        repeat (3) step(1, 8'd5, 0, 0, 0, 0, 0);
        chk("t2_credits", credits_out, 61);
        step(0, 0, 1, 8'd2, RSP_DONE, 1, 0);
        chk("t2_done", done_count_out, 1);
        chk("t2_credits_ret", credits_out, 62);

        // unknown tag, then tag 0: first offender is kept
        step(0, 0, 1, 8'h40, RSP_DONE, 0, 0);
        chk("t4_error_tag", error_tag_out, 8'h40);
        step(0, 0, 1, 8'h00, RSP_AERROR, 0, 0);
        chk("t4_error_tag_kept", error_tag_out, 8'h40);

        step(0, 0, 1, 8'd1, RSP_DONE, 1, 0);
        step(0, 0, 1, 8'd3, RSP_DONE, 1, 0);
        chk("t3_full_credits", credits_out, 64);

        // hold the request until credits run out
        ngrant = 0;
        repeat (70) begin
            step(1, 8'd7, 0, 0, 0, 0, 0);
            if (last_grant) ngrant++;
        end
        chk("t3_grants", ngrant, 64);
        chk("t3_credits_zero", credits_out, 0);

        // restore a few credits, then grant and retire together
        step(0, 0, 1, infl[0], RSP_NRES, 5, 0);
        step(1, 8'd9, 1, infl[0], RSP_DONE, 1, 0);
        chk("t5_credits", credits_out, 5);

        // statistics and clear
        step(0, 0, 1, infl[0], RSP_PAGED, 0, 0);
        step(0, 0, 1, infl[0], RSP_FLUSHED, 0, 0);
        step(0, 0, 1, infl[0], 8'h0F, 0, 0);
        chk("t6_paged", paged_count_out, 1);
        chk("t6_flushed", flushed_count_out, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, infl[0], RSP_DONE, 0, 1);
        chk("t6_cleared_done", done_count_out, 0);

        // credit clamping at both ends
        step(0, 0, 1, infl[0], RSP_FAULT, -20, 0);
        chk("clamp_low", credits_out, 0);
        step(0, 0, 1, infl[0], RSP_FAILED, 200, 0);
        chk("clamp_high", credits_out, 64);

        // steady traffic: every tag cycles through the free list
        repeat (300) begin
            if (infl.size() != 0)
                step(1, 8'($urandom), 1, infl[0], 8'($urandom_range(0, 15)), 1, 0);
            else
                step(1, 8'($urandom), 0, 0, 0, 0, 0);
        end

        repeat (2) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capi_tag_response_tracker.md
Name: capi_tag_response_tracker

Overview:
- Response-side companion to the AFU command path.
- Hands out PSL command tags and charges one PSL credit per issued command.
- On each PSL response: looks up the issuing CU ID, retires the tag, returns credits, and forwards the response tagged with that CU ID.
- Accumulates per-response-code statistics for the MMIO statistics registers (DONE_COUNT_REG … NLOCK_COUNT_REG).
- Sits between the command arbiter and the PSL response interface in afu_control.

Parameters:
- TAG_COUNT, 256: tag space size; tag 0 (INVALID_TAG) is never issued, so 255 tags are usable.
- TAG_BITS, $clog2(TAG_COUNT): tag width.
- CU_ID_RANGE, 8: width of the CU ID.
- CREDITS_TOTAL, 64: initial and maximum PSL credits.
- STAT_BITS, 64: width of each statistics counter.

Ports:
- clock  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- stats_clear_in  in  1  synchronous clear of all statistics counters
- ready_out  out  1  free list initialised; tag allocation allowed
- cmd_req_in  in  1  command arbiter requests a tag
- cmd_cu_id_in  in  CU_ID_RANGE  ID of the requesting CU
- cmd_grant_out  out  1  combinational grant, valid in the same cycle as the request
- cmd_tag_out  out  TAG_BITS  granted tag
- rsp_valid_in  in  1  PSL response strobe
- rsp_tag_in  in  TAG_BITS  response tag
- rsp_code_in  in  8  PSL response code
- rsp_credits_in  in  9  signed credit return
- rsp_valid_out  out  1  routed response valid
- rsp_cu_id_out  out  CU_ID_RANGE  issuing CU ID
- rsp_tag_out  out  TAG_BITS  response tag
- rsp_code_out  out  8  response code
- credits_out  out  7  credits currently available
- outstanding_out  out  9  tags currently in flight
- error_out  out  1  sticky: unknown tag seen or credit overflow
- error_tag_out  out  TAG_BITS  first offending tag
- done/aerror/derror/nlock/nres/flushed/fault/failed/paged_count_out  out  STAT_BITS each  per-code counters

Behaviour:
- Reset (async, rstn=0), all outputs to zero except:
  - credits_out = CREDITS_TOTAL
  - tag table valid bits cleared
  - FSM enters INIT
- INIT state:
  - Pushes tags 1..255 into the free-list FIFO, one per cycle (255 cycles).
  - Then moves to RUN and sets ready_out=1.
  - Responses arriving in INIT are flagged as unknown-tag errors and dropped.
- RUN state:
  - Grant condition: cmd_grant_out = cmd_req_in & ready_out & free_list_not_empty & (credits_out != 0).
  - cmd_tag_out = free-list head, shown even without a request.
  - On grant:
    - pop the head;
    - write table[tag] = {valid=1, cmd_cu_id_in};
    - credits -1;
    - outstanding +1.
  - On rsp_valid_in, with an entry valid for rsp_tag_in and tag != 0:
    - next cycle: rsp_valid_out=1, with cu_id from the table and tag/code registered (1-cycle latency);
    - clear table valid;
    - push the tag to the free list;
    - outstanding -1.
  - On rsp_valid_in with an invalid entry or tag 0:
    - no rsp_valid_out, no push;
    - error_out set (sticky until reset);
    - error_tag_out captured on the first error only.
  - Credits:
    - every response adds sign-extended rsp_credits_in, including responses with an unknown tag;
    - the same-cycle grant decrement is applied in the same update;
    - result saturates to [0, CREDITS_TOTAL];
    - a clipped result above CREDITS_TOTAL sets error_out.
- Simultaneous grant and retire: push and pop happen in the same cycle. A retired tag cannot be re-granted in its retirement cycle; it is granted at the earliest the next cycle.
- Free list: 256-deep FIFO with wrapping pointers plus an occupancy count. It can never overflow, because only valid tags are pushed.
- Statistics: one counter per code, incremented one cycle after the response; counters wrap.
  - Code map: DONE 0x00, AERROR 0x01, DERROR 0x03, NLOCK 0x04, NRES 0x05, FLUSHED 0x06, FAULT 0x07, FAILED 0x08, PAGED 0x0A.
  - Other codes: no counter, response still routed.
  - stats_clear_in has priority over an increment in the same cycle.

Decomposition:
- Add to GLOBALS_AFU_PKG:
  - PSL response-code constants;
  - tag_t typedef;
  - the tag_entry_t struct {valid, cu_id_t cu_id};
  - stats_t struct holding the nine counters.
- Sub-module: tag_free_list_fifo, the parameterised FIFO with init-load port.

Test Plan:
1. Reset release -> ready_out=0 for 255 cycles, then 1; credits_out=64; outstanding_out=0.
2. Grant 3 requests from CU 5 -> tags 1, 2, 3 issued, credits_out=61. Then DONE response for tag 2 with credits=+1 -> next cycle rsp_valid_out, cu_id=5, tag=2; done_count=1; credits_out=62.
3. Hold cmd_req_in with no responses -> exactly 64 grants, then cmd_grant_out=0 while credits_out=0.
4. Response tag=0x40 never issued -> no rsp_valid_out, error_out=1, error_tag_out=0x40, outstanding unchanged.
5. Grant and retire in the same cycle with credits=+1 -> credits unchanged, outstanding unchanged, retired tag appears at the free-list tail.
6. PAGED, then FLUSHED, then code 0x0F, then stats_clear_in -> paged=1, flushed=1, all counters 0 after the clear; the 0x0F response is still routed.
